// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// a live fill count, sticky overflow/underflow flags and selectable FWFT read.

module fifo_sync_prog_chk #(
    parameter int AW = 4
) (
    input logic          clk,
    input logic          reset,
    input logic [AW:0]   wr_ptr,
    input logic [AW:0]   rd_ptr,
    input logic [AW:0]   count
);
    // Pointer distance (modulo 2*DEPTH) must always equal the occupancy count
    a_ptr_count: assert property (@(posedge clk) disable iff (reset)
        (wr_ptr - rd_ptr) == count)
        else $error("fifo_sync_prog: pointer difference disagrees with count");
endmodule

module fifo_sync_prog #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 1
) (
    input  logic                     wr_clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    din,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     rd_en,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);
    localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fifo_sync_prog: DEPTH must be a power of two and >= 2");
        end
        if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
            $error("fifo_sync_prog: AF_THRESH must be in 1..DEPTH");
        end
        if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
            $error("fifo_sync_prog: AE_THRESH must be in 0..DEPTH-1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc_s, rd_acc_s;

    // Flags come from the registered count only, never from wr_en/rd_en
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == {(AW+1){1'b0}});
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc_s = wr_en && !full;
    assign rd_acc_s = rd_en && !empty;

    // Next-state for pointers, occupancy and sticky error flags
    always_comb begin
        wr_ptr_d    = wr_acc_s ? (wr_ptr_q + ONE_C) : wr_ptr_q;
        rd_ptr_d    = rd_acc_s ? (rd_ptr_q + ONE_C) : rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
        // A same-cycle set beats clr_err
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (rd_en && empty) begin
            underflow_d = 1'b1;
        end else if (clr_err) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            wr_ptr_q    <= {(AW+1){1'b0}};
            rd_ptr_q    <= {(AW+1){1'b0}};
            count_q     <= {(AW+1){1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; not reset, and a write in a reset cycle is dropped
    always_ff @(posedge wr_clk) begin
        if (wr_acc_s && !reset) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout = empty ? {DATA_WIDTH{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            // Registered read: load head on an accepted read, hold otherwise
            always_ff @(posedge wr_clk) begin
                if (reset) begin
                    dout_q <= {DATA_WIDTH{1'b0}};
                end else if (rd_acc_s) begin
                    dout_q <= mem_q[rd_ptr_q[AW-1:0]];
                end
            end
            assign dout = dout_q;
        end
    endgenerate

    fifo_sync_prog_chk #(.AW(AW)) u_chk (
        .clk    (wr_clk),
        .reset  (reset),
        .wr_ptr (wr_ptr_q),
        .rd_ptr (rd_ptr_q),
        .count  (count_q)
    );
endmodule

// File: tb/tb_fifo_sync_prog.sv
// Self-checking bench: a FWFT instance driven from a vector table and a
// scoreboard, plus a standard-read instance for the registered read path.
module tb_fifo_sync_prog;
    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en, rd_en, clr_err;
    logic [7:0] din;
    logic       full, almost_full, empty, almost_empty, overflow, underflow;
    logic [7:0] dout;
    logic [3:0] count;

    logic       s_wr_en, s_rd_en, s_clr_err;
    logic [7:0] s_din;
    logic       s_full, s_almost_full, s_empty, s_almost_empty, s_overflow, s_underflow;
    logic [7:0] s_dout;
    logic [3:0] s_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_sync_prog #(.DATA_WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) u_dut (
        .wr_clk(clk), .reset(reset), .wr_en(wr_en), .din(din), .full(full),
        .almost_full(almost_full), .rd_en(rd_en), .dout(dout), .empty(empty),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow), .clr_err(clr_err)
    );

    fifo_sync_prog #(.DATA_WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) u_std (
        .wr_clk(clk), .reset(reset), .wr_en(s_wr_en), .din(s_din), .full(s_full),
        .almost_full(s_almost_full), .rd_en(s_rd_en), .dout(s_dout), .empty(s_empty),
        .almost_empty(s_almost_empty), .count(s_count), .overflow(s_overflow),
        .underflow(s_underflow), .clr_err(s_clr_err)
    );

    typedef struct {
        logic       wr, rd, clr;
        logic [7:0] din;
        logic [3:0] cnt;
        logic       full, af, emp, ae, ovf, unf;
        logic [7:0] dout;
    } vec_t;

    vec_t       tbl [20];
    logic [7:0] exp_q [$];

    function automatic vec_t mk(logic wr, logic rd, logic clr, logic [7:0] d, logic [3:0] c,
                                logic f, logic af, logic e, logic ae, logic ov, logic un,
                                logic [7:0] q);
        vec_t v;
        v.wr = wr; v.rd = rd; v.clr = clr; v.din = d; v.cnt = c;
        v.full = f; v.af = af; v.emp = e; v.ae = ae; v.ovf = ov; v.unf = un; v.dout = q;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // {count, full, af, empty, ae, ovf, unf, dout} of the FWFT instance
    function automatic logic [31:0] obs();
        return {14'd0, count, full, almost_full, empty, almost_empty, overflow, underflow, dout};
    endfunction

    function automatic logic [31:0] expv(vec_t v);
        return {14'd0, v.cnt, v.full, v.af, v.emp, v.ae, v.ovf, v.unf, v.dout};
    endfunction

    initial begin
        logic [7:0] d;
        logic [7:0] e;

        // wr rd clr din   cnt full af emp ae ovf unf dout
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 8'h11, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11);
        tbl[1]  = mk(1'b1, 1'b0, 1'b0, 8'h12, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11);
        tbl[2]  = mk(1'b1, 1'b0, 1'b0, 8'h13, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11);
        tbl[3]  = mk(1'b1, 1'b0, 1'b0, 8'h14, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11);
        tbl[4]  = mk(1'b1, 1'b0, 1'b0, 8'h15, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11);
        tbl[5]  = mk(1'b1, 1'b0, 1'b0, 8'h16, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11);
        tbl[6]  = mk(1'b1, 1'b0, 1'b0, 8'h17, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11);
        tbl[7]  = mk(1'b1, 1'b0, 1'b0, 8'h18, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11);
        tbl[8]  = mk(1'b1, 1'b0, 1'b0, 8'hAA, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11);
        tbl[9]  = mk(1'b1, 1'b0, 1'b0, 8'hAA, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11);
        tbl[10] = mk(1'b0, 1'b0, 1'b1, 8'h00, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11);
        tbl[11] = mk(1'b0, 1'b1, 1'b0, 8'h00, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12);
        tbl[12] = mk(1'b0, 1'b1, 1'b0, 8'h00, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h13);
        tbl[13] = mk(1'b0, 1'b1, 1'b0, 8'h00, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h14);
        tbl[14] = mk(1'b0, 1'b1, 1'b0, 8'h00, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h15);
        tbl[15] = mk(1'b0, 1'b1, 1'b0, 8'h00, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h16);
        tbl[16] = mk(1'b0, 1'b1, 1'b0, 8'h00, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h17);
        tbl[17] = mk(1'b0, 1'b1, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h18);
        tbl[18] = mk(1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        tbl[19] = mk(1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);

        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = 8'h00;
        s_wr_en = 1'b0; s_rd_en = 1'b0; s_clr_err = 1'b0; s_din = 8'h00;
        tick(); tick();
        reset = 1'b0;
        chk("reset_fwft", obs(), {14'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00});
        chk("reset_std", {s_count, s_empty, s_almost_empty, s_full, s_almost_full, s_dout},
            {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00});

        // Standard registered read path
        s_wr_en = 1'b1; s_din = 8'h5A; tick(); s_wr_en = 1'b0;
        chk("std_after_write_dout", {24'd0, s_dout}, 32'h00);
        chk("std_after_write_count", {28'd0, s_count}, 32'd1);
        s_rd_en = 1'b1; tick(); s_rd_en = 1'b0;
        chk("std_read_dout", {24'd0, s_dout}, 32'h5A);
        chk("std_read_empty", {31'd0, s_empty}, 32'd1);
        tick();
        chk("std_hold_dout", {24'd0, s_dout}, 32'h5A);
        s_rd_en = 1'b1; tick(); s_rd_en = 1'b0;
        chk("std_underflow", {31'd0, s_underflow}, 32'd1);
        chk("std_rejected_read_dout", {24'd0, s_dout}, 32'h5A);

        // Fill, overflow, clear, drain, underflow
        for (int i = 0; i < 20; i++) begin
            wr_en = tbl[i].wr; rd_en = tbl[i].rd; clr_err = tbl[i].clr; din = tbl[i].din;
            tick();
            chk($sformatf("vec[%0d]", i), obs(), expv(tbl[i]));
        end
        wr_en = 1'b0; rd_en = 1'b0;
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("clr_underflow", {31'd0, underflow}, 32'd0);

        // Concurrent read/write streaming with scoreboard, pointers wrap
        d = 8'h40;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; din = d; exp_q.push_back(d); d = d + 8'd1; tick();
        end
        wr_en = 1'b0;
        chk("stream_fill_count", {28'd0, count}, 32'd4);
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; din = d;
            e = exp_q.pop_front();
            chk($sformatf("stream_dout[%0d]", i), {24'd0, dout}, {24'd0, e});
            exp_q.push_back(d); d = d + 8'd1;
            tick();
            chk($sformatf("stream_count[%0d]", i), {28'd0, count}, 32'd4);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1;
            e = exp_q.pop_front();
            chk($sformatf("drain_dout[%0d]", i), {24'd0, dout}, {24'd0, e});
            tick();
        end
        rd_en = 1'b0;
        chk("drain_empty", {27'd0, count, empty}, {27'd0, 4'd0, 1'b1});

        // Reset mid-burst at count=5 with a same-cycle write and read
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; din = 8'h70 + 8'(i); tick();
        end
        chk("midrst_pre_count", {28'd0, count}, 32'd5);
        chk("midrst_pre_unf", {31'd0, underflow}, 32'd1);
        wr_en = 1'b1; rd_en = 1'b1; din = 8'hEE; reset = 1'b1;
        tick();
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        chk("midrst_state", obs(), {14'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00});
        chk("midrst_std_dout", {24'd0, s_dout}, 32'h00);
        tick();
        chk("midrst_write_discarded", obs(), {14'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
